mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
- Sequences one shared single-port 32-bit memory between two pipe_MIPS32 requesters: instruction fetch (IF stage) and data load/store (MEM stage).
- Priority: data port wins by default. A streak counter stops fetch from starving.
- A branch-flush input discards an in-flight fetch result.
- Sits between the pipeline stage logic and the Mem array, replacing direct array indexing.

Parameters:
- AW, 10, memory word-address width (1024 words).
- DW, 32, data width.
- MEM_LAT, 1, cycles from the mem_en cycle until mem_rdata is valid (≥1).
- MAX_STREAK, 3, number of consecutive data grants allowed while i_req is pending (≥1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ack or i_flush.
- i_addr  in  AW  fetch word address.
- i_flush  in  1  taken branch; cancels pending or in-flight fetch.
- i_ack  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  DW  fetched instruction.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data word address.
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle pulse; load data valid or store done.
- d_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset (synchronous):
  - State goes to IDLE.
  - All outputs are 0: i_ack, d_ack, i_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata.
  - Internal registers cleared: owner, squash flag, streak counter, wait counter.
- Reset mid-operation aborts the transaction with no ack. A store whose mem_en already issued is not undone.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration (requests sampled here only):
  - Grant data when d_req=1 and not (i_req_eff=1 and streak==MAX_STREAK).
  - Otherwise grant fetch if i_req_eff=1.
  - i_req_eff = i_req & ~i_flush.
  - On a grant: latch owner, address, we and wdata, then go to ISSUE.
- Streak counter:
  - Increments on each data grant made while i_req_eff=1.
  - Clears on a fetch grant, or in IDLE when i_req_eff=0.
  - Saturates at MAX_STREAK.
- ISSUE:
  - mem_en=1 for exactly this cycle, with mem_addr, mem_we and mem_wdata driven.
  - Load the wait counter with MEM_LAT-1, then go to WAIT.
- WAIT:
  - Decrement the counter.
  - In the cycle where the counter is 0, capture mem_rdata into the owner's rdata register and go to RESP.
  - For stores, rdata is left unchanged.
- RESP:
  - Owner's ack=1 for one cycle, then go to IDLE.
  - req is ignored in RESP. Requesters deassert or change req on the edge that ends the ack cycle.
- Latency: request sampled in IDLE at cycle N, ack asserted in cycle N+2+MEM_LAT (N+3 at default). Throughput is one access per 3+MEM_LAT cycles.
- Flush:
  - i_flush=1 while the owner is fetch (ISSUE, WAIT or RESP-pending) sets the squash flag.
  - The memory read still completes. i_ack is suppressed and i_rdata is not updated.
  - The squash flag clears on return to IDLE.
  - i_flush in IDLE with i_req=1 means no fetch grant that cycle.
  - i_flush during a data access has no effect on it.
- Simultaneous d_req and i_req with streak<MAX_STREAK: data granted.
- Requests arriving outside IDLE wait; nothing is queued beyond the held req.
- Address wrap: none. Addresses are AW bits and are used as given.

Decomposition:
- Package mips_mem_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - owner constants OWN_I=1'b0, OWN_D=1'b1.
- Sub-module mips_mem_prio is the grant decision plus streak counter. It is small and sequential, and is reused if a third requester (DMA) is added.

Test Plan:
- Single fetch: i_req=1, i_addr=5, memory word 5 = 32'h280a00c8, held from cycle 0 → mem_en at cycle 1; i_ack at cycle 3 with i_rdata=32'h280a00c8; d_ack=0 throughout.
- Store then load: d_we=1, d_addr=198, d_wdata=5040, then d_we=0, d_addr=198 → first d_ack at cycle 3 with mem_we=1 seen at cycle 1; second d_ack with d_rdata=5040.
- Contention: i_req and d_req both held continuously, MAX_STREAK=3 → grant order D,D,D,I,D,D,D,I; no i_ack gap exceeds 4 transactions.
- Flush in flight: fetch granted at cycle 0, i_flush=1 at cycle 2 → mem_en still at cycle 1; no i_ack; i_rdata keeps its old value; next IDLE accepts a new i_req.
- Reset mid-access: rst=1 during WAIT of a load → next cycle IDLE, all outputs 0, no d_ack; a fresh d_req afterwards completes normally.
- MEM_LAT=3 build: single load → d_ack at cycle N+5 with data sampled from mem_rdata at cycle N+4.

Source files
------------

// File: rtl/mips_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the pipe_MIPS32 memory arbiter:
//   - arb_state_e : arbiter FSM state encoding
//   - OWN_I/OWN_D : owner of the access currently in flight
//   - cnt_width() : bit width needed to hold a counter value 0..max_val
// ---------------------------------------------------------------------------
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Never returns 0 so that a counter with max value 0 still has one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter_if
// Bundles every handshake/bus signal of the arbiter:
//   fetch port  : i_req, i_addr, i_flush -> i_ack, i_rdata
//   data port   : d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata
//   memory port : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
// Modports:
//   slave  - the arbiter itself
//   master - the surroundings (pipeline stages plus the memory array)
// ---------------------------------------------------------------------------
interface mips_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, i_flush,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr, i_flush,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mips_mem_arbiter_prio.sv
// ---------------------------------------------------------------------------
// mips_mem_prio
// Grant decision between the data and fetch requesters plus the anti-starvation
// streak counter. Data wins unless fetch is pending and data has already won
// MAX_STREAK consecutive arbitrations while fetch was waiting.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   arb_en_i     : arbiter is in IDLE; grants and counter updates only then
//   d_req_i      : data request
//   i_req_eff_i  : fetch request already masked by flush
//   grant_d_o    : grant data this cycle (combinational)
//   grant_i_o    : grant fetch this cycle (combinational)
// ---------------------------------------------------------------------------
module mips_mem_prio
  import mips_mem_pkg::*;
#(
  parameter int MAX_STREAK = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en_i,
  input  logic d_req_i,
  input  logic i_req_eff_i,
  output logic grant_d_o,
  output logic grant_i_o
);

  localparam int              SW         = cnt_width(MAX_STREAK);
  localparam logic [SW-1:0]   STREAK_CAP = SW'(MAX_STREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          at_cap;

  assign at_cap    = (streak_q == STREAK_CAP);
  assign grant_d_o = arb_en_i & d_req_i & ~(i_req_eff_i & at_cap);
  assign grant_i_o = arb_en_i & i_req_eff_i & ~grant_d_o;

  // The streak only measures how long fetch has been overtaken, so it resets
  // whenever fetch wins or stops asking.
  always_comb begin
    streak_d = streak_q;
    if (arb_en_i) begin
      if (!i_req_eff_i || grant_i_o) begin
        streak_d = '0;
      end else if (grant_d_o && !at_cap) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
// Shares one single-port memory between the IF-stage fetch port and the
// MEM-stage load/store port. One access at a time: IDLE -> ISSUE -> WAIT ->
// RESP, ack in cycle N+2+MEM_LAT for a request sampled in IDLE at cycle N.
// A fetch flushed while in flight still reads memory but is neither acked nor
// written into i_rdata.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave view of mips_mem_arbiter_if (fetch, data, memory ports)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 3
) (
  input  logic                clk,
  input  logic                rst,
  mips_mem_arbiter_if.slave   bus
);

  localparam int            WW        = cnt_width(MEM_LAT - 1);
  localparam logic [WW-1:0] WAIT_INIT = WW'(MEM_LAT - 1);

  arb_state_e    state_q;
  logic          owner_q;
  logic          we_q;       // access type, kept after mem_we drops
  logic          squash_q;
  logic [WW-1:0] wait_q;

  logic          i_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic i_req_eff;
  logic grant_d;
  logic grant_i;
  logic flush_hit;
  logic squash_now;

  assign i_req_eff  = bus.i_req & ~bus.i_flush;
  assign flush_hit  = (owner_q == OWN_I) & bus.i_flush;
  // A flush arriving in the capture cycle itself must still kill the result.
  assign squash_now = squash_q | flush_hit;

  mips_mem_prio #(
    .MAX_STREAK (MAX_STREAK)
  ) u_prio (
    .clk         (clk),
    .rst         (rst),
    .arb_en_i    (state_q == IDLE),
    .d_req_i     (bus.d_req),
    .i_req_eff_i (i_req_eff),
    .grant_d_o   (grant_d),
    .grant_i_o   (grant_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      we_q        <= 1'b0;
      squash_q    <= 1'b0;
      wait_q      <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          squash_q <= 1'b0;
          // mem_en/mem_we are set here so they are high during ISSUE.
          if (grant_d) begin
            owner_q     <= OWN_D;
            we_q        <= bus.d_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            state_q     <= ISSUE;
          end else if (grant_i) begin
            owner_q     <= OWN_I;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            state_q     <= ISSUE;
          end
        end

        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          wait_q   <= WAIT_INIT;
          if (flush_hit) squash_q <= 1'b1;
          state_q  <= WAIT;
        end

        WAIT: begin
          if (flush_hit) squash_q <= 1'b1;
          if (wait_q == '0) begin
            state_q <= RESP;
            if (owner_q == OWN_D) begin
              if (!we_q) d_rdata_q <= bus.mem_rdata;
              d_ack_q <= 1'b1;
            end else if (!squash_now) begin
              i_rdata_q <= bus.mem_rdata;
              i_ack_q   <= 1'b1;
            end
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end

        RESP: begin
          i_ack_q  <= 1'b0;
          d_ack_q  <= 1'b0;
          squash_q <= 1'b0;
          state_q  <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_arbiter
// Bench for mips_mem_arbiter: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, each with its own behavioural memory. Expected responses go into
// a scoreboard queue when a request is driven and are popped on each ack.
// ---------------------------------------------------------------------------
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct {
    logic          is_d;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_mem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
  mips_mem_arbiter_if #(.AW(AW), .DW(DW)) b3 ();

  mips_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .MAX_STREAK(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  mips_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .MAX_STREAK(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  // Behavioural memories; data outside the valid read slot is poisoned.
  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] mem3 [1024];
  logic [DW-1:0] p3 [2];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) begin
      mem1[pre_addr] <= pre_data;
      mem3[pre_addr] <= pre_data;
    end
    if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
    b1.mem_rdata <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr] : 32'hDEAD_BEEF;
    if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
    p3[0]        <= (b3.mem_en && !b3.mem_we) ? mem3[b3.mem_addr] : 32'hDEAD_BEEF;
    p3[1]        <= p3[0];
    b3.mem_rdata <= p3[1];
  end

  exp_t          sb[$];
  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] i_rdata_model = '0;

  function automatic logic [DW-1:0] word_of(input int a);
    if (a == 5) return 32'h280a00c8;
    return 32'hA500_0000 + DW'(a) * 32'h111;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int a = 0; a < 1024; a++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = AW'(a); pre_data = word_of(a);
    end
    @(negedge clk);
    pre_we = 1'b0;
    n_total++;
    if ({b1.i_ack, b1.d_ack, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.i_rdata, b1.d_rdata} !== '0)
      $display("FAIL reset_outputs_lat1: i_ack=%0b d_ack=%0b mem_en=%0b mem_we=%0b addr=%0d wdata=%h i_rdata=%h d_rdata=%h, required all 0",
               b1.i_ack, b1.d_ack, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.i_rdata, b1.d_rdata);
    else n_pass++;
    n_total++;
    if ({b3.i_ack, b3.d_ack, b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata, b3.i_rdata, b3.d_rdata} !== '0)
      $display("FAIL reset_outputs_lat3: mem_en=%0b addr=%0d d_rdata=%h, required all 0", b3.mem_en, b3.mem_addr, b3.d_rdata);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({b1.i_ack, b1.d_ack, b1.mem_en} !== 3'b000)
      $display("FAIL idle_after_reset: i_ack=%0b d_ack=%0b mem_en=%0b, required 0/0/0", b1.i_ack, b1.d_ack, b1.mem_en);
    else n_pass++;
  endtask

  task automatic test_single_fetch();
    exp_t e;
    int   ack_k = -1;
    bit   d_seen = 0;
    sb.delete();
    sb.push_back('{is_d: 1'b0, data: word_of(5)});
    @(negedge clk);
    b1.i_req = 1'b1; b1.i_addr = 10'd5;
    for (int k = 1; k <= 8 && ack_k < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_total++;
        if (b1.mem_en !== 1'b1 || b1.mem_addr !== 10'd5 || b1.mem_we !== 1'b0)
          $display("FAIL fetch_issue: mem_en=%0b addr=%0d we=%0b, required 1/5/0", b1.mem_en, b1.mem_addr, b1.mem_we);
        else n_pass++;
      end
      if (b1.d_ack) d_seen = 1;
      if (b1.i_ack) begin
        ack_k = k;
        b1.i_req = 1'b0;
        e = sb.pop_front();
        i_rdata_model = e.data;
        n_total++;
        if (b1.i_rdata !== e.data)
          $display("FAIL fetch_data: i_rdata=%h, required %h", b1.i_rdata, e.data);
        else n_pass++;
      end
    end
    n_total++;
    if (ack_k !== 3) $display("FAIL fetch_latency: i_ack at cycle %0d, required 3", ack_k);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (b1.i_ack !== 1'b0 || d_seen)
      $display("FAIL fetch_pulse: i_ack=%0b d_ack_seen=%0b, required 0/0", b1.i_ack, d_seen);
    else n_pass++;
  endtask

  task automatic test_store_load();
    exp_t e;
    int   ack_k;
    bit   i_seen = 0;
    sb.delete();
    sb.push_back('{is_d: 1'b1, data: 32'd0});    // store leaves d_rdata alone
    sb.push_back('{is_d: 1'b1, data: 32'd5040});
    @(negedge clk);
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 10'd198; b1.d_wdata = 32'd5040;
    for (int t = 0; t < 2; t++) begin
      ack_k = -1;
      for (int k = 1; k <= 8 && ack_k < 0; k++) begin
        @(negedge clk);
        if (b1.i_ack) i_seen = 1;
        if (k == 1) begin
          n_total++;
          if (b1.mem_en !== 1'b1 || b1.mem_we !== (t == 0) || b1.mem_addr !== 10'd198 ||
              (t == 0 && b1.mem_wdata !== 32'd5040))
            $display("FAIL sl_issue%0d: mem_en=%0b we=%0b addr=%0d wdata=%0d, required 1/%0b/198/5040",
                     t, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, t == 0);
          else n_pass++;
        end
        if (b1.d_ack) begin
          ack_k = k;
          e = sb.pop_front();
          n_total++;
          if (b1.d_rdata !== e.data)
            $display("FAIL sl_data%0d: d_rdata=%0d, required %0d", t, b1.d_rdata, e.data);
          else n_pass++;
          if (t == 0) begin b1.d_we = 1'b0; b1.d_wdata = '0; end
          else b1.d_req = 1'b0;
        end
      end
      n_total++;
      if (ack_k !== 3) $display("FAIL sl_latency%0d: d_ack at cycle %0d, required 3", t, ack_k);
      else n_pass++;
      if (t == 0) begin
        @(negedge clk);
        n_total++;
        if (b1.d_ack !== 1'b0) $display("FAIL sl_pulse: d_ack=%0b, required 0", b1.d_ack);
        else n_pass++;
      end
    end
    n_total++;
    if (i_seen) $display("FAIL sl_no_iack: i_ack seen=1, required 0");
    else n_pass++;
  endtask

  task automatic test_contention();
    exp_t          e;
    int            acks = 0, nd = 0, ni = 0, last_c = 0;
    logic [DW-1:0] got;
    sb.delete();
    for (int g = 0; g < 2; g++) begin
      for (int j = 0; j < 3; j++) sb.push_back('{is_d: 1'b1, data: word_of(30 + 3 * g + j)});
      sb.push_back('{is_d: 1'b0, data: word_of(20 + g)});
    end
    @(negedge clk);
    b1.i_req = 1'b1; b1.i_addr = 10'd20;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 10'd30;
    for (int c = 1; c <= 60 && acks < 8; c++) begin
      @(negedge clk);
      if (b1.i_ack || b1.d_ack) begin
        acks++;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL cont_extra_ack: ack %0d with empty scoreboard", acks);
        end else begin
          e = sb.pop_front();
          n_total++;
          if (b1.d_ack !== e.is_d || b1.i_ack === b1.d_ack)
            $display("FAIL cont_order%0d: i_ack=%0b d_ack=%0b, required owner %s", acks, b1.i_ack, b1.d_ack, e.is_d ? "D" : "I");
          else n_pass++;
          got = b1.d_ack ? b1.d_rdata : b1.i_rdata;
          n_total++;
          if (got !== e.data) $display("FAIL cont_data%0d: rdata=%h, required %h", acks, got, e.data);
          else n_pass++;
          if (!e.is_d) i_rdata_model = e.data;
        end
        n_total++;
        if ((c - last_c) !== ((acks == 1) ? 3 : 4))
          $display("FAIL cont_period%0d: %0d cycles since previous, required %0d", acks, c - last_c, (acks == 1) ? 3 : 4);
        else n_pass++;
        last_c = c;
        if (b1.d_ack) begin nd++; b1.d_addr = AW'(30 + nd); end
        else begin ni++; b1.i_addr = AW'(20 + ni); end
        if (acks == 8) begin b1.i_req = 1'b0; b1.d_req = 1'b0; end
      end
    end
    n_total++;
    if (acks !== 8) begin
      $display("FAIL cont_count: %0d acks, required 8", acks);
      b1.i_req = 1'b0; b1.d_req = 1'b0;
    end else n_pass++;
  endtask

  task automatic test_flush();
    exp_t e;
    int   ack_k = -1;
    bit   i_seen = 0;
    sb.delete();
    @(negedge clk);
    b1.i_req = 1'b1; b1.i_addr = 10'd40;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (b1.i_ack) i_seen = 1;
      if (k == 1) begin
        n_total++;
        if (b1.mem_en !== 1'b1 || b1.mem_addr !== 10'd40)
          $display("FAIL flush_issue: mem_en=%0b addr=%0d, required 1/40", b1.mem_en, b1.mem_addr);
        else n_pass++;
      end
      if (k == 2) begin b1.i_flush = 1'b1; b1.i_req = 1'b0; end
      if (k == 3) b1.i_flush = 1'b0;
    end
    n_total++;
    if (i_seen) $display("FAIL flush_no_ack: i_ack seen=1, required 0");
    else n_pass++;
    n_total++;
    if (b1.i_rdata !== i_rdata_model)
      $display("FAIL flush_rdata_kept: i_rdata=%h, required %h", b1.i_rdata, i_rdata_model);
    else n_pass++;

    // Flush in IDLE blocks the grant for that cycle only.
    b1.i_req = 1'b1; b1.i_flush = 1'b1; b1.i_addr = 10'd41;
    @(negedge clk);
    n_total++;
    if (b1.mem_en !== 1'b0) $display("FAIL flush_idle_nogrant: mem_en=%0b, required 0", b1.mem_en);
    else n_pass++;
    b1.i_flush = 1'b0;
    sb.push_back('{is_d: 1'b0, data: word_of(41)});
    for (int k = 1; k <= 8 && ack_k < 0; k++) begin
      @(negedge clk);
      if (b1.i_ack) begin
        ack_k = k;
        b1.i_req = 1'b0;
        e = sb.pop_front();
        i_rdata_model = e.data;
        n_total++;
        if (b1.i_rdata !== e.data) $display("FAIL flush_refetch_data: i_rdata=%h, required %h", b1.i_rdata, e.data);
        else n_pass++;
      end
    end
    b1.i_req = 1'b0;
    n_total++;
    if (ack_k !== 3) $display("FAIL flush_refetch_latency: i_ack at cycle %0d, required 3", ack_k);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   ack_k = -1;
    sb.delete();
    @(negedge clk);
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 10'd50;
    @(negedge clk);
    @(negedge clk);                          // cycle 2: WAIT
    rst = 1'b1; b1.d_req = 1'b0;
    @(negedge clk);
    n_total++;
    if ({b1.i_ack, b1.d_ack, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.i_rdata, b1.d_rdata} !== '0)
      $display("FAIL rstmid_outputs: d_ack=%0b mem_en=%0b addr=%0d i_rdata=%h d_rdata=%h, required all 0",
               b1.d_ack, b1.mem_en, b1.mem_addr, b1.i_rdata, b1.d_rdata);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (b1.d_ack !== 1'b0 || b1.mem_en !== 1'b0)
      $display("FAIL rstmid_no_ack: d_ack=%0b mem_en=%0b, required 0/0", b1.d_ack, b1.mem_en);
    else n_pass++;
    sb.push_back('{is_d: 1'b1, data: word_of(50)});
    b1.d_req = 1'b1;
    for (int k = 1; k <= 8 && ack_k < 0; k++) begin
      @(negedge clk);
      if (b1.d_ack) begin
        ack_k = k;
        b1.d_req = 1'b0;
        e = sb.pop_front();
        n_total++;
        if (b1.d_rdata !== e.data) $display("FAIL rstmid_reload_data: d_rdata=%h, required %h", b1.d_rdata, e.data);
        else n_pass++;
      end
    end
    b1.d_req = 1'b0;
    n_total++;
    if (ack_k !== 3) $display("FAIL rstmid_reload_latency: d_ack at cycle %0d, required 3", ack_k);
    else n_pass++;
  endtask

  task automatic test_lat3();
    exp_t e;
    int   ack_k = -1;
    sb.delete();
    sb.push_back('{is_d: 1'b1, data: word_of(7)});
    @(negedge clk);
    b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 10'd7;
    for (int k = 1; k <= 10 && ack_k < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_total++;
        if (b3.mem_en !== 1'b1 || b3.mem_addr !== 10'd7)
          $display("FAIL lat3_issue: mem_en=%0b addr=%0d, required 1/7", b3.mem_en, b3.mem_addr);
        else n_pass++;
      end
      if (b3.d_ack) begin
        ack_k = k;
        b3.d_req = 1'b0;
        e = sb.pop_front();
        n_total++;
        if (b3.d_rdata !== e.data) $display("FAIL lat3_data: d_rdata=%h, required %h", b3.d_rdata, e.data);
        else n_pass++;
      end
    end
    b3.d_req = 1'b0;
    n_total++;
    if (ack_k !== 5) $display("FAIL lat3_latency: d_ack at cycle %0d, required 5", ack_k);
    else n_pass++;
  endtask

  initial begin
    b1.i_req = 1'b0; b1.i_addr = '0; b1.i_flush = 1'b0;
    b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.i_req = 1'b0; b3.i_addr = '0; b3.i_flush = 1'b0;
    b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_addr = '0; b3.d_wdata = '0;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_flush();
    test_reset_mid();
    test_lat3();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
